seg7_scan_ctrl: RTL

- Time-multiplexing scan controller for an N-digit common-anode 7-segment display.
- Holds a packed BCD value and presents one digit at a time on a 4-bit BCD bus to the shared segment7 decoder.
- Drives the matching active-low digit enable, with a blanking gap between digits to prevent ghosting.
- Display updates are double-buffered and committed only at frame boundaries, so a frame never tears.

---
 rtl/seg7_scan_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for an N-digit
// common-anode 7-segment display.
//
// One BCD digit at a time goes to a shared segment decoder.
// The matching anode is enabled (active low).
// A blanking gap is inserted before each digit slot.
// New values are double-buffered and take effect only at frame boundaries.
//
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero suppression.
// A digit k > 0 stays dark when it and every more-significant digit are 0.
// Digit 0 is always lit.
//
// state | meaning
// BLANK | all anodes off; gap before the next digit slot (idle while en = 0)
// SHOW  | anode of digit idx on; bcd_out carries that digit
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]        active_q, active_d;
  logic [DW-1:0]        shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic                 frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [3:0]           bcd_q, bcd_d;
  logic                 frame_end;
  logic [NUM_DIGITS-1:0] dark_mask;

`ifdef SEG7_LZ_BLANK_EN
  // Mark digits (other than digit 0) that are leading zeros of the next active value.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    dark_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc = acc & (active_d[4*k +: 4] == 4'h0);
      dark_mask[k] = acc && (k > 0);
    end
  end
`else
  assign dark_mask = '0;
`endif

  // Scan sequencing and buffer management.
  // The slot counter counts up and ends its slot on a terminal-count match.
  // Entering a slot sets the counter to 1, so an idle BLANK (counter 0) takes one extra edge.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    frame_end    = 1'b0;

    if (!en) begin
      state_d = ST_BLANK;
      idx_d   = '0;
      cnt_d   = '0;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (load) begin
        active_d = digits_in;
        shadow_d = digits_in;
      end
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_TC) begin
            state_d = ST_SHOW;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_TC) begin
            state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            cnt_d   = CNT_W'(1);
            if (idx_q == LAST_IDX) begin
              idx_d        = '0;
              frame_end    = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_BLANK;
      endcase

      if (frame_end && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end

      // A load landing on the commit edge bypasses the shadow and shows next frame.
      if (load) begin
        shadow_d = digits_in;
        if (frame_end) begin
          active_d = digits_in;
        end else begin
          pending_d = 1'b1;
        end
      end
    end
  end

  // Registered outputs follow the next state so they line up with the state register.
  always_comb begin
    an_n_d = '1;
    if (state_d == ST_SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if ((idx_d == IDX_W'(k)) && !dark_mask[k]) begin
          an_n_d[k] = 1'b0;
        end
      end
    end
    bcd_d = active_d[{idx_d, 2'b00} +: 4];
  end

  // State, buffers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_n_q       <= '1;
      bcd_q        <= 4'h0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_n_q       <= an_n_d;
      bcd_q        <= bcd_d;
    end
  end

  assign an_n       = an_n_q;
  assign bcd_out    = bcd_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule
